// File: rtl/ring_counter_ctrl.sv
// Job engine for the ring counter: queues terminal counts, then runs clear/enable/hold
// sequencing for each job and returns the final count on a valid/ready response port.
module ring_counter_ctrl #(
  parameter int DEPTH       = 4,
  parameter int CLR_CYCLES  = 2,
  parameter int HOLD_CYCLES = 3,
  parameter int TIMEOUT     = 600,
  parameter int WD_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_cnt_i,
  output logic       cnt_rst_o,
  output logic       cnt_en_o,
  output logic [7:0] cnt_num_o,
  input  logic [7:0] cnt_val_i,
  input  logic       cnt_done_i,
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_cnt_o,
  output logic       rsp_err_o,
  output logic       busy_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam int PH_MAX = (CLR_CYCLES > HOLD_CYCLES) ? CLR_CYCLES : HOLD_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [PH_W-1:0] CLR_LAST  = PH_W'(CLR_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST = PH_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX    = '1;
  localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_HOLD,
    S_RESP
  } state_t;

  state_t state_reg, state_next;

  // Request FIFO storage
  logic [7:0]  fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0] count_reg;
  logic [7:0]  head;
  logic        push;
  logic        pop;

  // Sequencing counters
  logic [PH_W-1:0] ph_reg;
  logic [WD_W-1:0] wd_reg;

  // Registered outputs
  logic       cnt_rst_reg, cnt_rst_next;
  logic       cnt_en_reg, cnt_en_next;
  logic       rsp_valid_reg, rsp_valid_next;
  logic [7:0] cnt_num_reg;
  logic [7:0] rsp_cnt_reg;
  logic       rsp_err_reg;

  assign head        = fifo_mem[rd_ptr_reg];
  assign req_ready_o = (count_reg != FIFO_FULL);
  assign push        = req_valid_i && req_ready_o;
  assign pop         = (state_reg == S_IDLE) && (count_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= req_cnt_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (pop) begin
          state_next = (head == 8'd0) ? S_RESP : S_CLR;
        end
      end
      S_CLR: begin
        if (ph_reg == CLR_LAST) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        // Done takes priority over a coincident watchdog expiry.
        if (cnt_done_i) begin
          state_next = (HOLD_CYCLES == 0) ? S_RESP : S_HOLD;
        end else if (wd_reg == WD_LAST) begin
          state_next = S_RESP;
        end
      end
      S_HOLD: begin
        if (ph_reg == HOLD_LAST) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM: outputs, decoded from the upcoming state so they register cleanly
  always_comb begin
    cnt_rst_next   = 1'b0;
    cnt_en_next    = 1'b0;
    rsp_valid_next = 1'b0;
    case (state_next)
      S_CLR:   cnt_rst_next   = 1'b1;
      S_RUN:   cnt_en_next    = 1'b1;
      S_HOLD:  cnt_en_next    = 1'b1;
      S_RESP:  rsp_valid_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rst_reg   <= 1'b0;
      cnt_en_reg    <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      cnt_rst_reg   <= cnt_rst_next;
      cnt_en_reg    <= cnt_en_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  // Phase counter times CLR and HOLD; restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      ph_reg <= '0;
    end else if (state_next != state_reg) begin
      ph_reg <= '0;
    end else if (state_reg == S_CLR || state_reg == S_HOLD) begin
      ph_reg <= ph_reg + 1'b1;
    end
  end

  // Watchdog is held at zero outside RUN and saturates inside it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_reg <= '0;
    end else if (state_reg != S_RUN) begin
      wd_reg <= '0;
    end else if (wd_reg != WD_MAX) begin
      wd_reg <= wd_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_num_reg <= 8'd0;
      rsp_cnt_reg <= 8'd0;
      rsp_err_reg <= 1'b0;
    end else begin
      if (pop) begin
        cnt_num_reg <= head;
        if (head == 8'd0) begin
          rsp_cnt_reg <= 8'd0;
          rsp_err_reg <= 1'b0;
        end
      end
      if (state_reg == S_RUN) begin
        if (cnt_done_i) begin
          rsp_cnt_reg <= cnt_val_i;
          rsp_err_reg <= 1'b0;
        end else if (wd_reg == WD_LAST) begin
          rsp_cnt_reg <= cnt_val_i;
          rsp_err_reg <= 1'b1;
        end
      end
    end
  end

  assign cnt_rst_o   = cnt_rst_reg;
  assign cnt_en_o    = cnt_en_reg;
  assign cnt_num_o   = cnt_num_reg;
  assign rsp_valid_o = rsp_valid_reg;
  assign rsp_cnt_o   = rsp_cnt_reg;
  assign rsp_err_o   = rsp_err_reg;
  assign busy_o      = (state_reg != S_IDLE) || (count_reg != '0);

endmodule

// File: tb/tb_ring_counter_ctrl.sv
// Directed bench for ring_counter_ctrl with a behavioural ring counter attached
// to the en / num_cnt / done side.
module tb_ring_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready_o;
  logic [7:0] req_cnt;
  logic       cnt_rst_o;
  logic       cnt_en_o;
  logic [7:0] cnt_num_o;
  logic [7:0] cnt_val_i;
  logic       cnt_done_i;
  logic       rsp_valid_o;
  logic       rsp_ready;
  logic [7:0] rsp_cnt_o;
  logic       rsp_err_o;
  logic       busy_o;

  int total = 0;
  int bad   = 0;

  ring_counter_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_cnt_i  (req_cnt),
    .cnt_rst_o  (cnt_rst_o),
    .cnt_en_o   (cnt_en_o),
    .cnt_num_o  (cnt_num_o),
    .cnt_val_i  (cnt_val_i),
    .cnt_done_i (cnt_done_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready),
    .rsp_cnt_o  (rsp_cnt_o),
    .rsp_err_o  (rsp_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  // Counter model: stops at its terminal count, or free-runs when done is suppressed.
  logic [7:0] val = 8'd0;
  logic       no_done = 1'b0;

  always @(posedge clk) begin
    if (cnt_rst_o) begin
      val <= 8'd0;
    end else if (cnt_en_o && (no_done || val != cnt_num_o)) begin
      val <= val + 8'd1;
    end
  end

  assign cnt_val_i  = val;
  assign cnt_done_i = !no_done && cnt_en_o && (val == cnt_num_o);

  // Monitor on the falling edge: cycle counts and completed responses.
  int         n_rst, n_en, n_both;
  logic [8:0] rsp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (cnt_rst_o) n_rst++;
      if (cnt_en_o) n_en++;
      if (cnt_rst_o && cnt_en_o) n_both++;
      if (rsp_valid_o && rsp_ready) rsp_q.push_back({rsp_err_o, rsp_cnt_o});
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    n_rst  = 0;
    n_en   = 0;
    n_both = 0;
    rsp_q.delete();
  endtask

  task automatic push_job(input logic [7:0] v);
    int w;
    w = 0;
    req_valid = 1'b1;
    req_cnt   = v;
    while (!req_ready_o && w < 200) begin
      tick();
      w++;
    end
    check_val($sformatf("push_rdy_%0d", v), req_ready_o, 1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int max, input string tag);
    int w;
    w = 0;
    while (!rsp_valid_o && w < max) begin
      tick();
      w++;
    end
    check_val(tag, rsp_valid_o, 1);
  endtask

  task automatic wait_q(input int n, input int max, input string tag);
    int w;
    w = 0;
    while (rsp_q.size() < n && w < max) begin
      tick();
      w++;
    end
    check_val(tag, rsp_q.size(), n);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got=stuck expected=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp5 [5];
    int unstable;
    int w;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_cnt   = 8'd0;
    rsp_ready = 1'b0;
    clear_mon();
    repeat (3) tick();

    check_val("rst_cnt_rst", cnt_rst_o, 0);
    check_val("rst_cnt_en", cnt_en_o, 0);
    check_val("rst_cnt_num", cnt_num_o, 0);
    check_val("rst_rsp_valid", rsp_valid_o, 0);
    check_val("rst_rsp_cnt", rsp_cnt_o, 0);
    check_val("rst_rsp_err", rsp_err_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_req_ready", req_ready_o, 1);
    rst = 1'b0;
    tick();

    // 1: single job of 30
    clear_mon();
    rsp_ready = 1'b1;
    push_job(8'd30);
    check_val("t1_busy_q", busy_o, 1);
    wait_rsp(100, "t1_rsp");
    check_val("t1_rsp_cnt", rsp_cnt_o, 30);
    check_val("t1_rsp_err", rsp_err_o, 0);
    tick();
    check_val("t1_busy_end", busy_o, 0);
    check_val("t1_n_rst", n_rst, 2);
    check_val("t1_n_en", n_en, 34);
    check_val("t1_overlap", n_both, 0);
    check_val("t1_nrsp", rsp_q.size(), 1);

    // 2: back-to-back 30 then 60
    clear_mon();
    push_job(8'd30);
    push_job(8'd60);
    wait_rsp(200, "t2_rsp1");
    check_val("t2_rsp1_cnt", rsp_cnt_o, 30);
    check_val("t2_num_first", cnt_num_o, 30);
    tick();
    check_val("t2_num_bubble", cnt_num_o, 30);
    check_val("t2_rst_bubble", cnt_rst_o, 0);
    tick();
    check_val("t2_num_second", cnt_num_o, 60);
    check_val("t2_rst_second", cnt_rst_o, 1);
    wait_rsp(200, "t2_rsp2");
    check_val("t2_rsp2_cnt", rsp_cnt_o, 60);
    tick();
    wait_q(2, 10, "t2_nrsp");
    check_val("t2_q0", (rsp_q.size() > 0) ? rsp_q[0] : 9'h1ff, {1'b0, 8'd30});
    check_val("t2_q1", (rsp_q.size() > 1) ? rsp_q[1] : 9'h1ff, {1'b0, 8'd60});
    check_val("t2_n_rst", n_rst, 4);
    check_val("t2_overlap", n_both, 0);

    // 3: zero-length job
    clear_mon();
    rsp_ready = 1'b0;
    push_job(8'd0);
    check_val("t3_early", rsp_valid_o, 0);
    tick();
    check_val("t3_valid", rsp_valid_o, 1);
    check_val("t3_cnt", rsp_cnt_o, 0);
    check_val("t3_err", rsp_err_o, 0);
    rsp_ready = 1'b1;
    tick();
    check_val("t3_n_rst", n_rst, 0);
    check_val("t3_n_en", n_en, 0);
    check_val("t3_nrsp", rsp_q.size(), 1);

    // 4: watchdog timeout, counter free-runs so last RUN value is 599 mod 256
    clear_mon();
    no_done = 1'b1;
    push_job(8'd50);
    wait_rsp(800, "t4_rsp");
    check_val("t4_n_en", n_en, 600);
    check_val("t4_err", rsp_err_o, 1);
    check_val("t4_cnt", rsp_cnt_o, 87);
    tick();
    no_done = 1'b0;
    check_val("t4_busy_end", busy_o, 0);

    // 5: fill the queue under response backpressure, then drain
    clear_mon();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp5[i] = 8'((i + 1) * 10);
      push_job(exp5[i]);
    end
    check_val("t5_full", req_ready_o, 0);
    check_val("t5_busy", busy_o, 1);
    wait_rsp(100, "t5_rsp");
    check_val("t5_first_cnt", rsp_cnt_o, 10);
    unstable = 0;
    repeat (10) begin
      tick();
      if (!rsp_valid_o || rsp_cnt_o != 8'd10 || rsp_err_o) unstable++;
    end
    check_val("t5_stall", unstable, 0);
    check_val("t5_still_full", req_ready_o, 0);
    rsp_ready = 1'b1;
    wait_q(5, 500, "t5_nrsp");
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("t5_q%0d", i), (i < rsp_q.size()) ? rsp_q[i] : 9'h1ff, {1'b0, exp5[i]});
    end
    tick();
    check_val("t5_ready_end", req_ready_o, 1);
    check_val("t5_busy_end", busy_o, 0);

    // 6: reset mid-RUN with jobs queued
    clear_mon();
    push_job(8'd100);
    push_job(8'd100);
    push_job(8'd100);
    w = 0;
    while (!cnt_en_o && w < 50) begin
      tick();
      w++;
    end
    check_val("t6_running", cnt_en_o, 1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check_val("t6_en", cnt_en_o, 0);
    check_val("t6_ready", req_ready_o, 1);
    check_val("t6_busy", busy_o, 0);
    check_val("t6_valid", rsp_valid_o, 0);
    rst = 1'b0;
    clear_mon();
    repeat (300) tick();
    check_val("t6_nrsp", rsp_q.size(), 0);
    check_val("t6_n_en", n_en, 0);
    check_val("t6_n_rst", n_rst, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
